// File: rtl/usb_ls_pkg.sv
// Shared definitions for the low-speed USB transmit path.
//   tx_state_t : transmitter FSM encoding
//   LINE_*     : {dp, dm} pad values for the bus line states
//   SYNC_BYTE  : sync pattern sent before every packet, LSB first
//   DEF_*      : default bit-time divider and bit-stuff run length
package usb_ls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam int DEF_CLK_DIV   = 8;
  localparam int DEF_STUFF_LEN = 6;

endpackage

// File: rtl/usb_ls_tx_if.sv
// Byte stream into the low-speed USB transmitter.
//   tx_data  : payload byte, sent LSB first
//   tx_valid : tx_data valid
//   tx_last  : tx_data is the final byte of the packet
//   tx_ready : byte accepted when tx_valid & tx_ready
// master = byte source, slave = transmitter.
interface usb_ls_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_tx_nrzi.sv
// Bit stuffer + NRZI encoder. On each strobe it consumes one raw bit and
// advances the line level; after STUFF_LEN consecutive ones the following
// strobe emits a stuffed zero instead (bit_in is ignored for that slot).
//   clk, reset    : clock, asynchronous active-low reset
//   clear         : restart with reference level J and an empty ones run
//   strobe        : advance one bit slot
//   bit_in        : raw bit for this slot
//   level_nxt     : line level after this slot (1 = K, 0 = J)
//   stuff_pending : the next slot is a stuffed zero
module usb_tx_nrzi
  import usb_ls_pkg::*;
#(
  parameter int STUFF_LEN = DEF_STUFF_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic strobe,
  input  logic bit_in,
  output logic level_nxt,
  output logic stuff_pending
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STUFF_LEN);

  logic          level;
  logic [CW-1:0] ones;
  logic          base_level;
  logic [CW-1:0] base_ones;
  logic [CW-1:0] ones_nxt;

  // clear and strobe together encode the first bit from a fresh J reference
  always_comb begin
    base_level = clear ? 1'b0 : level;
    base_ones  = clear ? '0 : ones;
    level_nxt  = base_level;
    ones_nxt   = base_ones;
    if ((base_ones == RUN_MAX) || !bit_in) begin
      level_nxt = ~base_level;
      ones_nxt  = '0;
    end else begin
      ones_nxt = base_ones + 1'b1;
    end
  end

  assign stuff_pending = (ones == RUN_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      ones  <= '0;
    end else if (strobe) begin
      level <= level_nxt;
      ones  <= ones_nxt;
    end else if (clear) begin
      level <= 1'b0;
      ones  <= '0;
    end
  end

endmodule

// File: rtl/usb_ls_tx.sv
// Low-speed USB packet transmitter: SYNC, bit-stuffed NRZI payload, EOP.
//   clk, reset : 12 MHz clock, asynchronous active-low reset
//   tx         : byte stream (slave side of usb_ls_tx_if)
//   dp_out     : D+ drive value
//   dm_out     : D- drive value
//   oe         : pad output enable, 1 while a packet is on the bus
//   busy       : first byte accepted until end of EOP
//   underrun   : one-cycle pulse when a packet is cut short for lack of data
module usb_ls_tx
  import usb_ls_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int STUFF_LEN = DEF_STUFF_LEN
) (
  input  logic        clk,
  input  logic        reset,
  usb_ls_tx_if.slave  tx,
  output logic        dp_out,
  output logic        dm_out,
  output logic        oe,
  output logic        busy,
  output logic        underrun
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);

  tx_state_t   state, state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [2:0]  bit_idx, bit_idx_nxt, idx_inc;
  logic [7:0]  byte_q, byte_nxt, sync_byte;
  logic        last_q, last_nxt;
  logic [1:0]  line_fix, line_d;
  logic        oe_nxt, busy_nxt, underrun_nxt;
  logic        bit_end, boundary;
  logic        nrzi_clear, nrzi_strobe, nrzi_bit;
  logic        level_nxt, stuff_pending;

  usb_tx_nrzi #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
    .clk           (clk),
    .reset         (reset),
    .clear         (nrzi_clear),
    .strobe        (nrzi_strobe),
    .bit_in        (nrzi_bit),
    .level_nxt     (level_nxt),
    .stuff_pending (stuff_pending)
  );

  assign bit_end   = (bit_cnt == BIT_LAST);
  assign idx_inc   = bit_idx + 3'd1;
  assign sync_byte = SYNC_BYTE;
  // The only DATA cycle where the next byte may be taken: bit 7 is finishing,
  // no stuffed zero is owed and the current byte was not the last one.
  assign boundary  = (state == ST_DATA) && bit_end && (bit_idx == 3'd7) &&
                     !stuff_pending && !last_q;
  assign tx.tx_ready = (state == ST_IDLE) || boundary;

  // every encoded slot takes its level from the NRZI block
  assign line_d = nrzi_strobe ? (level_nxt ? LINE_K : LINE_J) : line_fix;

  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    byte_nxt     = byte_q;
    last_nxt     = last_q;
    line_fix     = {dp_out, dm_out};
    oe_nxt       = oe;
    busy_nxt     = busy;
    underrun_nxt = 1'b0;
    nrzi_clear   = 1'b0;
    nrzi_strobe  = 1'b0;
    nrzi_bit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx.tx_valid) begin
          byte_nxt    = tx.tx_data;
          last_nxt    = tx.tx_last;
          bit_idx_nxt = 3'd0;
          nrzi_clear  = 1'b1;
          nrzi_strobe = 1'b1;
          nrzi_bit    = sync_byte[0];
          oe_nxt      = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (bit_end) begin
          nrzi_strobe = 1'b1;
          if (bit_idx == 3'd7) begin
            nrzi_bit    = byte_q[0];
            bit_idx_nxt = 3'd0;
            state_nxt   = ST_DATA;
          end else begin
            nrzi_bit    = sync_byte[idx_inc];
            bit_idx_nxt = idx_inc;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (stuff_pending) begin
            // stuffed zero: bit index holds
            nrzi_strobe = 1'b1;
          end else if (bit_idx != 3'd7) begin
            nrzi_strobe = 1'b1;
            nrzi_bit    = byte_q[idx_inc];
            bit_idx_nxt = idx_inc;
          end else if (last_q) begin
            line_fix    = LINE_SE0;
            bit_idx_nxt = 3'd0;
            state_nxt   = ST_EOP_SE0;
          end else if (tx.tx_valid) begin
            byte_nxt    = tx.tx_data;
            last_nxt    = tx.tx_last;
            nrzi_strobe = 1'b1;
            nrzi_bit    = tx.tx_data[0];
            bit_idx_nxt = 3'd0;
          end else begin
            underrun_nxt = 1'b1;
            line_fix     = LINE_SE0;
            bit_idx_nxt  = 3'd0;
            state_nxt    = ST_EOP_SE0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx == 3'd0) begin
            bit_idx_nxt = 3'd1;
          end else begin
            line_fix    = LINE_J;
            bit_idx_nxt = 3'd0;
            state_nxt   = ST_EOP_J;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_end) begin
          oe_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      last_q   <= 1'b0;
      dp_out   <= 1'b0;
      dm_out   <= 1'b1;
      oe       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state            <= state_nxt;
      bit_idx          <= bit_idx_nxt;
      last_q           <= last_nxt;
      {dp_out, dm_out} <= line_d;
      oe               <= oe_nxt;
      busy             <= busy_nxt;
      underrun         <= underrun_nxt;
      // held at zero in IDLE, so every packet starts on a fresh bit time
      if ((state == ST_IDLE) || bit_end) bit_cnt <= '0;
      else                               bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_nxt;
  end

endmodule

// File: tb/tb_usb_ls_tx.sv
// Testbench for usb_ls_tx: drives packets over the byte stream, samples the
// pad line once per bit time and compares against a packet-level model
// (bit list -> stuffing -> NRZI) and an independent line decoder.
module tb_usb_ls_tx;

  localparam int CLK_DIV   = 8;
  localparam int STUFF_LEN = 6;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset;
  logic dp_out, dm_out, oe, busy, underrun;
  int   checks = 0;
  int   errors = 0;

  usb_ls_tx_if txif ();

  usb_ls_tx #(.CLK_DIV(CLK_DIV), .STUFF_LEN(STUFF_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx       (txif),
    .dp_out   (dp_out),
    .dm_out   (dm_out),
    .oe       (oe),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  logic [1:0] mon_line[$];
  logic [1:0] exp_line[$];
  int mon_oe_cyc, mon_busy_cyc, mon_ready_cnt, mon_under_cnt, mon_under_pos;
  int drv_accepted;
  bit mon_timeout;
  int bad_idx;
  logic [1:0] bad_act, bad_exp;

  // Expected line state per bit time, from the packet rules.
  task automatic build_expected(input byte_q_t bytes);
    bit raw[$];
    bit stuffed[$];
    logic [7:0] sync_v = 8'h80;
    logic [1:0] lvl = J;
    int run = 0;
    exp_line.delete();
    for (int k = 0; k < 8; k++) raw.push_back(sync_v[k]);
    foreach (bytes[i]) for (int k = 0; k < 8; k++) raw.push_back(bytes[i][k]);
    foreach (raw[i]) begin
      stuffed.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == STUFF_LEN) begin
        stuffed.push_back(1'b0);
        run = 0;
      end
    end
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl = (lvl == J) ? K : J;
      exp_line.push_back(lvl);
    end
    exp_line.push_back(SE0);
    exp_line.push_back(SE0);
    exp_line.push_back(J);
  endtask

  function automatic int line_diffs();
    int d = 0;
    bad_idx = -1;
    bad_act = 2'bxx;
    bad_exp = 2'bxx;
    if (mon_line.size() != exp_line.size()) d++;
    for (int i = 0; i < mon_line.size() && i < exp_line.size(); i++) begin
      if (mon_line[i] !== exp_line[i]) begin
        if (bad_idx < 0) begin
          bad_idx = i;
          bad_act = mon_line[i];
          bad_exp = exp_line[i];
        end
        d++;
      end
    end
    return d;
  endfunction

  task automatic drive_packet(input byte_q_t bytes, input bit abort);
    int i = 0;
    int guard = 0;
    while (i < bytes.size() && guard < 1500) begin
      @(negedge clk);
      txif.tx_valid = 1'b1;
      txif.tx_data  = bytes[i];
      txif.tx_last  = (i == bytes.size() - 1) && !abort;
      #1;
      if (txif.tx_ready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    txif.tx_valid = 1'b0;
    txif.tx_last  = 1'b0;
    drv_accepted  = i;
  endtask

  task automatic monitor_packet();
    int wait_cnt = 0;
    int n = 0;
    mon_line.delete();
    mon_oe_cyc = 0; mon_busy_cyc = 0; mon_ready_cnt = 0;
    mon_under_cnt = 0; mon_under_pos = -1; mon_timeout = 1'b0;
    while (oe !== 1'b1 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (oe !== 1'b1) begin
      mon_timeout = 1'b1;
      return;
    end
    while (oe === 1'b1 && n < 1500) begin
      if (n % CLK_DIV == CLK_DIV / 2) mon_line.push_back({dp_out, dm_out});
      if (busy === 1'b1) mon_busy_cyc++;
      if (txif.tx_ready === 1'b1) mon_ready_cnt++;
      if (underrun === 1'b1) begin
        mon_under_cnt++;
        if (mon_under_pos < 0) mon_under_pos = n;
      end
      n++;
      @(negedge clk);
    end
    mon_oe_cyc = n;
    if (oe === 1'b1) mon_timeout = 1'b1;
  endtask

  task automatic run_packet(input byte_q_t bytes, input bit abort);
    build_expected(bytes);
    fork
      drive_packet(bytes, abort);
      monitor_packet();
    join
  endtask

  task automatic test_reset();
    reset = 1'b0;
    txif.tx_valid = 1'b0; txif.tx_data = 8'h00; txif.tx_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dp_out, dm_out} !== J) begin errors++; $display("FAIL reset_line: got %b, want %b", {dp_out, dm_out}, J); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, want 0", oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b, want 0", underrun); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, want 1", txif.tx_ready); end
    checks++; if ({oe, dp_out, dm_out} !== 3'b001) begin errors++; $display("FAIL idle_bus: got %b, want 001", {oe, dp_out, dm_out}); end
  endtask

  task automatic test_single_zero();
    byte_q_t p;
    logic [1:0] tbl[19];
    p = {8'h00};
    tbl = '{K, J, K, J, K, J, K, K, J, K, J, K, J, K, J, K, SE0, SE0, J};
    run_packet(p, 1'b0);
    checks++; if (mon_timeout !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %b, want 0", mon_timeout); end
    checks++; if (mon_oe_cyc != 152) begin errors++; $display("FAIL zero_oe_cycles: got %0d, want 152", mon_oe_cyc); end
    checks++; if (mon_line.size() != 19) begin errors++; $display("FAIL zero_bit_times: got %0d, want 19", mon_line.size()); end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (i >= mon_line.size() || mon_line[i] !== tbl[i]) begin
        errors++;
        $display("FAIL zero_line bit %0d: got %b, want %b", i, (i < mon_line.size()) ? mon_line[i] : 2'bxx, tbl[i]);
      end
    end
    checks++; if (mon_under_cnt != 0) begin errors++; $display("FAIL zero_underrun: got %0d pulses, want 0", mon_under_cnt); end
  endtask

  task automatic test_single_ff();
    byte_q_t p;
    logic [1:0] tbl[20];
    p = {8'hFF};
    tbl = '{K, J, K, J, K, J, K, K, K, K, K, K, K, J, J, J, J, SE0, SE0, J};
    run_packet(p, 1'b0);
    checks++; if (mon_oe_cyc != 160) begin errors++; $display("FAIL ff_oe_cycles: got %0d, want 160", mon_oe_cyc); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (i >= mon_line.size() || mon_line[i] !== tbl[i]) begin
        errors++;
        $display("FAIL ff_line bit %0d: got %b, want %b", i, (i < mon_line.size()) ? mon_line[i] : 2'bxx, tbl[i]);
      end
    end
    checks++; if (mon_busy_cyc != mon_oe_cyc) begin errors++; $display("FAIL ff_busy_cycles: got %0d, want %0d", mon_busy_cyc, mon_oe_cyc); end
  endtask

  task automatic test_back_to_back();
    byte_q_t p;
    int d;
    p = {8'h2D, 8'h01, 8'h7F};
    run_packet(p, 1'b0);
    d = line_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL b2b_line: %0d diffs, first bit %0d got %b want %b", d, bad_idx, bad_act, bad_exp); end
    checks++; if (drv_accepted != 3) begin errors++; $display("FAIL b2b_accepted: got %0d, want 3", drv_accepted); end
    checks++; if (mon_ready_cnt != 2) begin errors++; $display("FAIL b2b_ready_in_packet: got %0d, want 2", mon_ready_cnt); end
    checks++; if (mon_oe_cyc != exp_line.size() * CLK_DIV) begin errors++; $display("FAIL b2b_oe_cycles: got %0d, want %0d", mon_oe_cyc, exp_line.size() * CLK_DIV); end
    checks++; if (mon_under_cnt != 0) begin errors++; $display("FAIL b2b_underrun: got %0d, want 0", mon_under_cnt); end
  endtask

  task automatic test_underrun();
    byte_q_t p;
    int d;
    p = {8'($urandom), 8'($urandom)};
    run_packet(p, 1'b1);
    d = line_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL ur_line: %0d diffs, first bit %0d got %b want %b", d, bad_idx, bad_act, bad_exp); end
    checks++; if (mon_under_cnt != 1) begin errors++; $display("FAIL ur_pulses: got %0d, want 1", mon_under_cnt); end
    checks++; if (mon_under_pos != (exp_line.size() - 3) * CLK_DIV) begin errors++; $display("FAIL ur_position: got %0d, want %0d", mon_under_pos, (exp_line.size() - 3) * CLK_DIV); end
    checks++; if (mon_oe_cyc - mon_under_pos != 3 * CLK_DIV) begin errors++; $display("FAIL ur_busy_tail: got %0d, want %0d", mon_oe_cyc - mon_under_pos, 3 * CLK_DIV); end
    checks++; if (mon_busy_cyc != mon_oe_cyc) begin errors++; $display("FAIL ur_busy_cycles: got %0d, want %0d", mon_busy_cyc, mon_oe_cyc); end
    checks++; if (drv_accepted != 2) begin errors++; $display("FAIL ur_accepted: got %0d, want 2", drv_accepted); end
  endtask

  task automatic test_stuff_tail();
    byte_q_t p;
    int d;
    p = {8'hFC};
    run_packet(p, 1'b0);
    d = line_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL tail_line: %0d diffs, first bit %0d got %b want %b", d, bad_idx, bad_act, bad_exp); end
    checks++; if (mon_oe_cyc != 160) begin errors++; $display("FAIL tail_oe_cycles: got %0d, want 160", mon_oe_cyc); end
    p = {8'hFC, 8'h01};
    run_packet(p, 1'b0);
    d = line_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL tail2_line: %0d diffs, first bit %0d got %b want %b", d, bad_idx, bad_act, bad_exp); end
    checks++; if (mon_ready_cnt != 1) begin errors++; $display("FAIL tail2_ready: got %0d, want 1", mon_ready_cnt); end
  endtask

  task automatic test_random();
    byte_q_t p;
    int n, d;
    for (int r = 0; r < 6; r++) begin
      p.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) p.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_packet(p, 1'b0);
      d = line_diffs();
      checks++; if (d != 0) begin errors++; $display("FAIL rand%0d_line: %0d diffs, first bit %0d got %b want %b", r, d, bad_idx, bad_act, bad_exp); end
      checks++; if (mon_oe_cyc != exp_line.size() * CLK_DIV) begin errors++; $display("FAIL rand%0d_oe_cycles: got %0d, want %0d", r, mon_oe_cyc, exp_line.size() * CLK_DIV); end
      checks++; if (mon_ready_cnt != n - 1) begin errors++; $display("FAIL rand%0d_ready: got %0d, want %0d", r, mon_ready_cnt, n - 1); end
      checks++; if (drv_accepted != n) begin errors++; $display("FAIL rand%0d_accepted: got %0d, want %0d", r, drv_accepted, n); end
    end
  endtask

  task automatic test_reset_mid_packet();
    byte_q_t p;
    int d;
    @(negedge clk);
    txif.tx_valid = 1'b1; txif.tx_data = 8'h55; txif.tx_last = 1'b1;
    @(negedge clk);
    txif.tx_valid = 1'b0; txif.tx_last = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before: got %b, want 1", oe); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({oe, dp_out, dm_out, busy} !== 4'b0010) begin errors++; $display("FAIL mid_reset_outputs: got %b, want 0010", {oe, dp_out, dm_out, busy}); end
    @(negedge clk);
    reset = 1'b1;
    p = {8'($urandom), 8'($urandom)};
    run_packet(p, 1'b0);
    d = line_diffs();
    checks++; if (d != 0) begin errors++; $display("FAIL mid_restart_line: %0d diffs, first bit %0d got %b want %b", d, bad_idx, bad_act, bad_exp); end
  endtask

  task automatic test_loopback();
    byte_q_t p;
    byte_q_t dec;
    bit bits[$];
    logic [1:0] prev;
    logic [7:0] sync_v, acc;
    int run, i;
    bit drop, b, eop_ok;
    p = {8'hA5, 8'h3C};
    run_packet(p, 1'b0);
    prev = J; run = 0; drop = 1'b0; i = 0; sync_v = 8'h00; eop_ok = 1'b0;
    while (i < mon_line.size() && mon_line[i] !== SE0) begin
      b = (mon_line[i] === prev);
      prev = mon_line[i];
      if (drop) drop = 1'b0;
      else begin
        bits.push_back(b);
        run = b ? run + 1 : 0;
        if (run == STUFF_LEN) begin
          drop = 1'b1;
          run = 0;
        end
      end
      i++;
    end
    if (mon_line.size() == i + 3)
      eop_ok = (mon_line[i] === SE0) && (mon_line[i + 1] === SE0) && (mon_line[i + 2] === J);
    if (bits.size() >= 8) for (int k = 0; k < 8; k++) sync_v[k] = bits[k];
    for (int j = 8; j + 8 <= bits.size(); j += 8) begin
      for (int k = 0; k < 8; k++) acc[k] = bits[j + k];
      dec.push_back(acc);
    end
    checks++; if (sync_v !== 8'h80) begin errors++; $display("FAIL loop_sync: got %h, want 80", sync_v); end
    checks++; if (bits.size() != 24) begin errors++; $display("FAIL loop_bit_count: got %0d, want 24", bits.size()); end
    checks++; if (dec.size() != 2) begin errors++; $display("FAIL loop_byte_count: got %0d, want 2", dec.size()); end
    else begin
      checks++; if (dec[0] !== 8'hA5) begin errors++; $display("FAIL loop_byte0: got %h, want a5", dec[0]); end
      checks++; if (dec[1] !== 8'h3C) begin errors++; $display("FAIL loop_byte1: got %h, want 3c", dec[1]); end
    end
    checks++; if (eop_ok !== 1'b1) begin errors++; $display("FAIL loop_eop: got %b, want 1", eop_ok); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_zero();
    test_single_ff();
    test_back_to_back();
    test_underrun();
    test_stuff_tail();
    test_random();
    test_reset_mid_packet();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
